rf_commit_sched: RTL and testbench

Commit-write scheduler between the ROB commit stage and the register file's single write port. Buffers committed writes `{rd, value, rob tag}` in a small FIFO and drains one per cycle into the register file, stalling when the register file is busy or a flush is in progress. Forwards still-pending committed values to operand reads so decode never sees a stale register. Committed writes are architectural: a flush never discards them; it only invalidates their rename tags.

---
 rtl/rf_commit_sched.sv | 132 +++++++++++++
 tb/tb_rf_commit_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_commit_sched.sv
// rf_commit_sched: buffers committed register writes from the ROB and drains
// them one per cycle into the register file's single write port. Pending
// values are forwarded to operand lookups so decode never reads stale data.
// A flush keeps the writes (they are architectural) but drops their rename tags.
module rf_commit_sched #(
    parameter int DEPTH         = 4,
    parameter int REG_NUM_WIDTH = 5,
    parameter int ROB_W         = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       need_flush_in,
    input  logic                       rob_valid,
    input  logic [REG_NUM_WIDTH-1:0]   rob_rd,
    input  logic [31:0]                rob_value,
    input  logic [ROB_W-1:0]           rob_dependency,
    output logic                       rob_ready,
    input  logic                       rf_busy_in,
    output logic                       rf_valid,
    output logic [REG_NUM_WIDTH-1:0]   rf_rd,
    output logic [31:0]                rf_value,
    output logic [ROB_W-1:0]           rf_dependency,
    input  logic [REG_NUM_WIDTH-1:0]   q_rs1,
    input  logic [REG_NUM_WIDTH-1:0]   q_rs2,
    output logic                       q_hit1,
    output logic                       q_hit2,
    output logic [31:0]                q_value1,
    output logic [31:0]                q_value2,
    output logic [$clog2(DEPTH):0]     count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][REG_NUM_WIDTH-1:0] rd_q, rd_d;
    logic [DEPTH-1:0][31:0]              value_q, value_d;
    logic [DEPTH-1:0][ROB_W-1:0]         tag_q, tag_d;
    logic [DEPTH-1:0]                    tag_valid_q, tag_valid_d;
    logic [PW-1:0]                       head_q, head_d;
    logic [PW-1:0]                       tail_q, tail_d;
    logic [CW-1:0]                       count_q, count_d;

    logic enq;
    logic flush;
    logic drain;

    // Full/drain status depends only on registered state plus the stall inputs.
    assign rob_ready     = (count_q < CW'(DEPTH));
    assign drain         = rdy_in && (count_q != '0) && !rf_busy_in && !need_flush_in;
    assign flush         = rdy_in && need_flush_in;
    assign enq           = rdy_in && rob_valid && rob_ready && (rob_rd != '0);
    assign rf_valid      = drain;
    assign rf_rd         = rd_q[head_q];
    assign rf_value      = value_q[head_q];
    assign rf_dependency = tag_valid_q[head_q] ? tag_q[head_q] : '1;
    assign count_out     = count_q;

    // Next-state: flush clears tags, drain pops head, enqueue pushes tail.
    // Flush and drain are mutually exclusive; enqueue never targets the head
    // slot while a drain is in progress because the FIFO is then non-empty
    // and not full.
    always_comb begin
        rd_d        = rd_q;
        value_d     = value_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        if (flush) begin
            tag_valid_d = '0;
        end
        if (drain) begin
            tag_valid_d[head_q] = 1'b0;
            head_d              = head_q + 1'b1;
        end
        if (enq) begin
            rd_d[tail_q]        = rob_rd;
            value_d[tail_q]     = rob_value;
            tag_d[tail_q]       = rob_dependency;
            tag_valid_d[tail_q] = !flush;
            tail_d              = tail_q + 1'b1;
        end
        count_d = count_q + CW'(enq) - CW'(drain);
    end

    // State registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_q        <= '0;
            value_q     <= '0;
            tag_q       <= '0;
            tag_valid_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else if (rdy_in) begin
            rd_q        <= rd_d;
            value_q     <= value_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    // Operand forwarding: walk oldest to youngest so the last match wins.
    logic [PW-1:0] fidx;
    always_comb begin
        q_hit1   = 1'b0;
        q_hit2   = 1'b0;
        q_value1 = '0;
        q_value2 = '0;
        fidx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fidx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (q_rs1 != '0 && rd_q[fidx] == q_rs1) begin
                    q_hit1   = 1'b1;
                    q_value1 = value_q[fidx];
                end
                if (q_rs2 != '0 && rd_q[fidx] == q_rs2) begin
                    q_hit2   = 1'b1;
                    q_value2 = value_q[fidx];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_commit_sched.sv
module tb_rf_commit_sched;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        need_flush_in;
    logic        rob_valid;
    logic [4:0]  rob_rd;
    logic [31:0] rob_value;
    logic [3:0]  rob_dependency;
    logic        rob_ready;
    logic        rf_busy_in;
    logic        rf_valid;
    logic [4:0]  rf_rd;
    logic [31:0] rf_value;
    logic [3:0]  rf_dependency;
    logic [4:0]  q_rs1, q_rs2;
    logic        q_hit1, q_hit2;
    logic [31:0] q_value1, q_value2;
    logic [2:0]  count_out;

    int errors = 0;
    int checks = 0;

    rf_commit_sched #(.DEPTH(4), .REG_NUM_WIDTH(5), .ROB_W(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
        .rob_valid(rob_valid), .rob_rd(rob_rd), .rob_value(rob_value),
        .rob_dependency(rob_dependency), .rob_ready(rob_ready), .rf_busy_in(rf_busy_in),
        .rf_valid(rf_valid), .rf_rd(rf_rd), .rf_value(rf_value), .rf_dependency(rf_dependency),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(q_hit1), .q_hit2(q_hit2),
        .q_value1(q_value1), .q_value2(q_value2), .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 2 units later, well away from either edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic offer(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] t);
        rob_valid      = 1'b1;
        rob_rd         = rd;
        rob_value      = v;
        rob_dependency = t;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; need_flush_in = 1'b0; rob_valid = 1'b0;
        rob_rd = '0; rob_value = '0; rob_dependency = '0; rf_busy_in = 1'b0;
        q_rs1 = '0; q_rs2 = '0;
        #12;
        checks++; if (rob_ready !== 1'b1) begin errors++; $display("FAIL reset_rob_ready got %b exp 1", rob_ready); end
        checks++; if (rf_valid !== 1'b0) begin errors++; $display("FAIL reset_rf_valid got %b exp 0", rf_valid); end
        checks++; if (rf_rd !== 5'd0 || rf_value !== 32'd0) begin errors++; $display("FAIL reset_rf_data got %h/%h exp 0/0", rf_rd, rf_value); end
        checks++; if (rf_dependency !== 4'hF) begin errors++; $display("FAIL reset_rf_dep got %h exp f", rf_dependency); end
        checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_out); end
        checks++; if (q_hit1 !== 1'b0 || q_value1 !== 32'd0) begin errors++; $display("FAIL reset_fwd got %b/%h exp 0/0", q_hit1, q_value1); end
        step();
        rst_in = 1'b0;
    endtask

    task automatic test_basic_write();
        offer(5'd5, 32'hDEADBEEF, 4'd3);
        settle();
        checks++; if (rf_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_valid got %b exp 0", rf_valid); end
        step();
        rob_valid = 1'b0;
        settle();
        checks++; if (count_out !== 3'd1) begin errors++; $display("FAIL basic_count1 got %0d exp 1", count_out); end
        checks++; if (rf_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", rf_valid); end
        checks++; if (rf_rd !== 5'd5 || rf_value !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data got %0d/%h exp 5/deadbeef", rf_rd, rf_value); end
        checks++; if (rf_dependency !== 4'd3) begin errors++; $display("FAIL basic_dep got %h exp 3", rf_dependency); end
        step();
        settle();
        checks++; if (count_out !== 3'd0 || rf_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got cnt=%0d vld=%b exp 0/0", count_out, rf_valid); end
    endtask

    task automatic test_full_fifo();
        rf_busy_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(5'(i + 1), 32'h100 + 32'(i), 4'(i));
            step();
        end
        settle();
        checks++; if (count_out !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count_out); end
        checks++; if (rob_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", rob_ready); end
        offer(5'd9, 32'h999, 4'd9);
        step();
        settle();
        checks++; if (count_out !== 3'd4) begin errors++; $display("FAIL full_fifth got %0d exp 4", count_out); end
        rob_valid  = 1'b0;
        rf_busy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if (rf_valid !== 1'b1 || rf_rd !== 5'(i + 1) || rf_value !== 32'h100 + 32'(i) || rf_dependency !== 4'(i)) begin
                errors++;
                $display("FAIL full_drain%0d got vld=%b rd=%0d val=%h dep=%h exp 1/%0d/%h/%h",
                         i, rf_valid, rf_rd, rf_value, rf_dependency, i + 1, 32'h100 + 32'(i), i);
            end
            step();
        end
        settle();
        checks++; if (count_out !== 3'd0 || rf_valid !== 1'b0) begin errors++; $display("FAIL full_empty got cnt=%0d vld=%b exp 0/0", count_out, rf_valid); end
    endtask

    task automatic test_flush();
        rf_busy_in = 1'b1;
        offer(5'd10, 32'hA0, 4'd1); step();
        offer(5'd11, 32'hB0, 4'd2); step();
        rf_busy_in    = 1'b0;
        need_flush_in = 1'b1;
        offer(5'd12, 32'hC0, 4'd3);
        settle();
        checks++; if (rf_valid !== 1'b0) begin errors++; $display("FAIL flush_no_drain got %b exp 0", rf_valid); end
        step();
        need_flush_in = 1'b0;
        rob_valid     = 1'b0;
        settle();
        checks++; if (count_out !== 3'd3) begin errors++; $display("FAIL flush_count got %0d exp 3", count_out); end
        checks++; if (rf_valid !== 1'b1 || rf_rd !== 5'd10 || rf_dependency !== 4'hF) begin errors++; $display("FAIL flush_w0 got vld=%b rd=%0d dep=%h exp 1/10/f", rf_valid, rf_rd, rf_dependency); end
        step(); settle();
        checks++; if (rf_valid !== 1'b1 || rf_rd !== 5'd11 || rf_dependency !== 4'hF) begin errors++; $display("FAIL flush_w1 got vld=%b rd=%0d dep=%h exp 1/11/f", rf_valid, rf_rd, rf_dependency); end
        step(); settle();
        checks++; if (rf_valid !== 1'b1 || rf_rd !== 5'd12 || rf_dependency !== 4'hF) begin errors++; $display("FAIL flush_w2 got vld=%b rd=%0d dep=%h exp 1/12/f", rf_valid, rf_rd, rf_dependency); end
        step(); settle();
        checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL flush_empty got %0d exp 0", count_out); end
    endtask

    task automatic test_forwarding();
        rf_busy_in = 1'b1;
        q_rs1 = 5'd7;
        q_rs2 = 5'd0;
        offer(5'd7, 32'h11, 4'd5);
        settle();
        checks++; if (q_hit1 !== 1'b0) begin errors++; $display("FAIL fwd_incoming got %b exp 0", q_hit1); end
        step();
        offer(5'd7, 32'h22, 4'd6);
        settle();
        checks++; if (q_hit1 !== 1'b1 || q_value1 !== 32'h11) begin errors++; $display("FAIL fwd_one got %b/%h exp 1/11", q_hit1, q_value1); end
        step();
        rob_valid = 1'b0;
        settle();
        checks++; if (q_hit1 !== 1'b1 || q_value1 !== 32'h22) begin errors++; $display("FAIL fwd_youngest got %b/%h exp 1/22", q_hit1, q_value1); end
        checks++; if (q_hit2 !== 1'b0 || q_value2 !== 32'd0) begin errors++; $display("FAIL fwd_x0 got %b/%h exp 0/0", q_hit2, q_value2); end
        rf_busy_in = 1'b0;
        step(); settle();
        checks++; if (rf_valid !== 1'b1 || q_hit1 !== 1'b1 || q_value1 !== 32'h22) begin errors++; $display("FAIL fwd_draining got vld=%b hit=%b val=%h exp 1/1/22", rf_valid, q_hit1, q_value1); end
        step(); settle();
        checks++; if (q_hit1 !== 1'b0 || q_value1 !== 32'd0) begin errors++; $display("FAIL fwd_after got %b/%h exp 0/0", q_hit1, q_value1); end
        q_rs1 = 5'd0;
    endtask

    task automatic test_x0_write();
        offer(5'd0, 32'h55, 4'd1);
        step();
        rob_valid = 1'b0;
        settle();
        checks++; if (count_out !== 3'd0 || rf_valid !== 1'b0) begin errors++; $display("FAIL x0_drop got cnt=%0d vld=%b exp 0/0", count_out, rf_valid); end
        step(); settle();
        checks++; if (rf_valid !== 1'b0) begin errors++; $display("FAIL x0_later got %b exp 0", rf_valid); end
    endtask

    task automatic test_back_to_back();
        offer(5'd20, 32'hA, 4'd1);
        step();
        offer(5'd21, 32'hB, 4'd2);
        settle();
        checks++; if (rf_valid !== 1'b1 || rf_rd !== 5'd20 || count_out !== 3'd1) begin errors++; $display("FAIL b2b_0 got vld=%b rd=%0d cnt=%0d exp 1/20/1", rf_valid, rf_rd, count_out); end
        step();
        offer(5'd22, 32'hC, 4'd3);
        settle();
        checks++; if (rf_valid !== 1'b1 || rf_rd !== 5'd21 || count_out !== 3'd1) begin errors++; $display("FAIL b2b_1 got vld=%b rd=%0d cnt=%0d exp 1/21/1", rf_valid, rf_rd, count_out); end
        step();
        rob_valid = 1'b0;
        settle();
        checks++; if (rf_valid !== 1'b1 || rf_rd !== 5'd22 || rf_value !== 32'hC) begin errors++; $display("FAIL b2b_2 got vld=%b rd=%0d val=%h exp 1/22/c", rf_valid, rf_rd, rf_value); end
        step(); settle();
        checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", count_out); end
    endtask

    task automatic test_stall_reset();
        rf_busy_in = 1'b1;
        offer(5'd3, 32'h33, 4'd7);
        step();
        rf_busy_in = 1'b0;
        rdy_in     = 1'b0;
        offer(5'd4, 32'h44, 4'd8);
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (rf_valid !== 1'b0 || count_out !== 3'd1) begin errors++; $display("FAIL stall%0d got vld=%b cnt=%0d exp 0/1", i, rf_valid, count_out); end
            step();
        end
        rdy_in    = 1'b1;
        rob_valid = 1'b0;
        settle();
        checks++; if (rf_valid !== 1'b1 || rf_rd !== 5'd3 || count_out !== 3'd1) begin errors++; $display("FAIL stall_resume got vld=%b rd=%0d cnt=%0d exp 1/3/1", rf_valid, rf_rd, count_out); end
        #2;
        rst_in = 1'b1;
        #1;
        checks++; if (count_out !== 3'd0 || rf_valid !== 1'b0) begin errors++; $display("FAIL async_reset got cnt=%0d vld=%b exp 0/0", count_out, rf_valid); end
        step();
        rst_in = 1'b0;
        step(); settle();
        checks++; if (count_out !== 3'd0 || rf_valid !== 1'b0) begin errors++; $display("FAIL post_reset got cnt=%0d vld=%b exp 0/0", count_out, rf_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_full_fifo();
        test_flush();
        test_forwarding();
        test_x0_write();
        test_back_to_back();
        test_stall_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
